// File: rtl/jt12_pow2_lin.sv
// jt12_pow2_lin: log-domain attenuation to linear operator sample.
// Adds log-sine and scaled envelope, looks up 2^x mantissa, shifts by integer part.
//
// Ports:
//   rst_n      async active-low reset
//   clk        core clock
//   clk_en     pipeline advance enable (all state holds when low)
//   din_valid  input sample valid
//   logsin     12-bit log-sine attenuation, 4.8 fixed point, 0 = full scale
//   sign       waveform sign, 1 = negative half cycle
//   eg_att     envelope attenuation, 0 = loudest
//   dout_valid output sample valid
//   dout       14-bit linear sample, one's-complement sign encoding
module jt12_pow2_lin #(
    parameter int EG_W     = 10,
    parameter int EG_SHIFT = 2
) (
    input  logic            rst_n,
    input  logic            clk,
    input  logic            clk_en,
    input  logic            din_valid,
    input  logic [11:0]     logsin,
    input  logic            sign,
    input  logic [EG_W-1:0] eg_att,
    output logic            dout_valid,
    output logic [13:0]     dout
);

    typedef struct packed {
        logic        v;
        logic        sign;
        logic [12:0] att;
    } s1_t;

    typedef struct packed {
        logic        v;
        logic        sign;
        logic [4:0]  shf;
        logic [9:0]  mant;
    } s2_t;

    // Fractional part of 2^x, x = i/256, scaled to 10 bits.
    // Evaluated only at elaboration to build the constant table.
    function automatic logic [9:0] pow2_entry(input int i);
        real r;
        r = 1024.0 * (2.0 ** (real'(i) / 256.0) - 1.0);
        return 10'($rtoi(r + 0.5));
    endfunction

    logic [9:0] rom [256];

    for (genvar g = 0; g < 256; g++) begin : g_rom
        localparam logic [9:0] VAL = pow2_entry(g);
        assign rom[g] = VAL;
    end

    s1_t s1;
    s2_t s2;

    logic [12:0] sum;
    logic [7:0]  rom_idx;
    logic [12:0] ext;
    logic [12:0] mag;

    // The sum never exceeds 0x1FFB, so 13 bits cannot overflow.
    assign sum = 13'(logsin) + (13'(eg_att) << EG_SHIFT);

    // Fraction is attenuation, so the table is read backwards.
    assign rom_idx = ~s1.att[7:0];

    // Implicit leading one, two guard bits; shifts of 13+ drain to 0.
    assign ext = {1'b1, s2.mant, 2'b00};
    assign mag = ext >> s2.shf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
        end else if (clk_en) begin
            s1.v    <= din_valid;
            s1.sign <= sign;
            s1.att  <= sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2 <= '0;
        end else if (clk_en) begin
            s2.v    <= s1.v;
            s2.sign <= s1.sign;
            s2.shf  <= s1.att[12:8];
            s2.mant <= rom[rom_idx];
        end
    end

    // Data path is not gated by valid: bubbles still update dout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (clk_en) begin
            dout       <= s2.sign ? ~{1'b0, mag} : {1'b0, mag};
            dout_valid <= s2.v;
        end
    end

endmodule

// File: tb/tb_jt12_pow2_lin.sv
// Testbench for jt12_pow2_lin: directed cases plus randomized sweep
// checked against a formula-level reference model.
module tb_jt12_pow2_lin;

    logic        rst_n;
    logic        clk;
    logic        clk_en;
    logic        din_valid;
    logic [11:0] logsin;
    logic        sign;
    logic [9:0]  eg_att;
    logic        dout_valid;
    logic [13:0] dout;

    int checks;
    int failures;

    jt12_pow2_lin #(.EG_W(10), .EG_SHIFT(2)) dut (
        .rst_n      (rst_n),
        .clk        (clk),
        .clk_en     (clk_en),
        .din_valid  (din_valid),
        .logsin     (logsin),
        .sign       (sign),
        .eg_att     (eg_att),
        .dout_valid (dout_valid),
        .dout       (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        logic [13:0] d;
    } item_t;

    item_t       pipe[$];
    bit          exp_v;
    logic [13:0] exp_d;

    // Linear value for a total attenuation: 2^(-att/256) scaled to 13 bits,
    // mantissa from the rounded table formula, sign applied as one's complement.
    function automatic logic [13:0] ref_out(input int att, input bit sgn);
        int          idx;
        int          m;
        int          shf;
        int          mag;
        real         r;
        logic [13:0] d;
        idx = 255 - (att % 256);
        r   = 1024.0 * (2.0 ** (real'(idx) / 256.0) - 1.0);
        m   = $rtoi(r + 0.5);
        shf = att / 256;
        mag = (shf >= 13) ? 0 : ((4096 + 4 * m) >> shf);
        d   = 14'(mag);
        return sgn ? ~d : d;
    endfunction

    // After reset the stages hold zeros: the S2 contents yield 0x1000,
    // the S1 contents (att=0) yield the full-scale value.
    task automatic model_reset();
        pipe.delete();
        pipe.push_back('{1'b0, 14'h1000});
        pipe.push_back('{1'b0, ref_out(0, 1'b0)});
        exp_v = 1'b0;
        exp_d = 14'h0000;
    endtask

    // One clock: inputs change 1 time unit after the edge, outputs
    // are sampled 1 time unit after the next edge.
    task automatic cyc(input bit en, input bit v, input logic [11:0] ls,
                       input bit sg, input logic [9:0] eg);
        item_t e;
        clk_en    = en;
        din_valid = v;
        logsin    = ls;
        sign      = sg;
        eg_att    = eg;
        @(posedge clk);
        #1;
        if (en) begin
            pipe.push_back('{v, ref_out(int'(ls) + 4 * int'(eg), sg)});
            e     = pipe.pop_front();
            exp_v = e.v;
            exp_d = e.d;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        clk_en    = 1'b1;
        din_valid = 1'b1;
        logsin    = 12'h123;
        sign      = 1'b1;
        eg_att    = 10'h055;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (dout !== 14'h0000) begin
            failures++;
            $display("FAIL reset_dout got=%h want=%h", dout, 14'h0000);
        end
        checks++;
        if (dout_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b want=0", dout_valid);
        end
        rst_n = 1'b1;
        model_reset();
        #1;
    endtask

    task automatic test_directed();
        logic [11:0] ls_t [6];
        logic [9:0]  eg_t [6];
        bit          sg_t [6];
        logic [13:0] want [6];
        ls_t = '{12'h000, 12'h000, 12'h100, 12'h0FF, 12'h859, 12'h859};
        eg_t = '{10'h000, 10'h000, 10'h000, 10'h000, 10'h3FF, 10'h3FF};
        sg_t = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        want = '{14'h1FE8, 14'h2017, 14'h0FF4, 14'h1000, 14'h0000, 14'h3FFF};
        for (int k = 0; k < 9; k++) begin
            if (k < 6) cyc(1'b1, 1'b1, ls_t[k], sg_t[k], eg_t[k]);
            else       cyc(1'b1, 1'b0, 12'h000, 1'b0, 10'h000);
            if (k >= 2 && k < 8) begin
                checks++;
                if (dout_valid !== 1'b1 || dout !== want[k-2]) begin
                    failures++;
                    $display("FAIL directed_%0d got=%b/%h want=1/%h",
                             k - 2, dout_valid, dout, want[k-2]);
                end
            end
        end
    endtask

    task automatic test_valid_pattern();
        bit vin [3];
        vin = '{1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 6; k++) begin
            if (k < 3) cyc(1'b1, vin[k], 12'(k * 64), 1'b0, 10'h010);
            else       cyc(1'b1, 1'b0, 12'h000, 1'b0, 10'h000);
            if (k >= 2 && k < 5) begin
                checks++;
                if (dout_valid !== vin[k-2]) begin
                    failures++;
                    $display("FAIL valid_pattern_%0d got=%b want=%b",
                             k - 2, dout_valid, vin[k-2]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [13:0] prev_d;
        bit          prev_v;
        int          seen;
        seen = 0;
        for (int k = 0; k < 22; k++) begin
            bit en;
            en     = (k % 2 == 0);
            prev_d = dout;
            prev_v = dout_valid;
            if (k < 16)
                cyc(en, en, 12'($urandom_range(0, 4095)), 1'($urandom),
                    10'($urandom_range(0, 1023)));
            else
                cyc(en, 1'b0, 12'h000, 1'b0, 10'h000);
            if (!en) begin
                checks++;
                if (dout !== prev_d || dout_valid !== prev_v) begin
                    failures++;
                    $display("FAIL b2b_hold_%0d got=%b/%h want=%b/%h",
                             k, dout_valid, dout, prev_v, prev_d);
                end
            end else begin
                if (exp_v) seen++;
                checks++;
                if (dout_valid !== exp_v || dout !== exp_d) begin
                    failures++;
                    $display("FAIL b2b_out_%0d got=%b/%h want=%b/%h",
                             k, dout_valid, dout, exp_v, exp_d);
                end
            end
        end
        checks++;
        if (seen != 8) begin
            failures++;
            $display("FAIL b2b_count got=%0d want=8", seen);
        end
    endtask

    task automatic test_async_reset();
        cyc(1'b1, 1'b1, 12'h010, 1'b0, 10'h001);
        cyc(1'b1, 1'b1, 12'h020, 1'b1, 10'h002);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dout !== 14'h0000 || dout_valid !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got=%b/%h want=0/0000",
                     dout_valid, dout);
        end
        model_reset();
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b0, 12'h000, 1'b0, 10'h000);
            checks++;
            if (dout_valid !== 1'b0) begin
                failures++;
                $display("FAIL post_reset_idle_%0d got=%b want=0",
                         k, dout_valid);
            end
        end
        cyc(1'b1, 1'b1, 12'h100, 1'b0, 10'h000);
        for (int k = 0; k < 3; k++) begin
            bit          wv;
            logic [13:0] wd;
            cyc(1'b1, 1'b0, 12'h000, 1'b0, 10'h000);
            wv = (k == 1);
            wd = 14'h0FF4;
            checks++;
            if (dout_valid !== wv || (wv && dout !== wd)) begin
                failures++;
                $display("FAIL post_reset_first_%0d got=%b/%h want=%b/%h",
                         k, dout_valid, dout, wv, wd);
            end
        end
    endtask

    // Every reachable attenuation (0..0x1FFB) in both signs, with a
    // random logsin/eg split, random clk_en gaps and random bubbles.
    task automatic test_sweep();
        int att;
        int lo;
        int hi;
        int eg;
        for (int s = 0; s < 2; s++) begin
            att = 0;
            while (att <= 16'h1FFB) begin
                bit          en;
                bit          v;
                logic [13:0] prev_d;
                bit          prev_v;
                en = ($urandom_range(0, 9) < 8);
                v  = ($urandom_range(0, 15) != 0);
                lo = (att > 4095) ? (att - 4095 + 3) / 4 : 0;
                hi = (att / 4 > 1023) ? 1023 : att / 4;
                eg = $urandom_range(lo, hi);
                prev_d = dout;
                prev_v = dout_valid;
                cyc(en, v, 12'(att - 4 * eg), 1'(s), 10'(eg));
                if (en && v) att++;
                if (!en) begin
                    checks++;
                    if (dout !== prev_d || dout_valid !== prev_v) begin
                        failures++;
                        $display("FAIL sweep_hold att=%h got=%b/%h want=%b/%h",
                                 att, dout_valid, dout, prev_v, prev_d);
                    end
                end else begin
                    checks++;
                    if (dout_valid !== exp_v || dout !== exp_d) begin
                        failures++;
                        $display("FAIL sweep_out att=%h got=%b/%h want=%b/%h",
                                 att, dout_valid, dout, exp_v, exp_d);
                    end
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b0, 12'h000, 1'b0, 10'h000);
            checks++;
            if (dout_valid !== exp_v || dout !== exp_d) begin
                failures++;
                $display("FAIL sweep_drain_%0d got=%b/%h want=%b/%h",
                         k, dout_valid, dout, exp_v, exp_d);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        model_reset();
        test_reset();
        test_directed();
        test_valid_pattern();
        test_back_to_back();
        test_async_reset();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
